// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO.
// Sticky frame/overrun flags are cleared by err_clr, which wins over a same-cycle error.
module uart_rx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overrun,
    input  logic          err_clr
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam int PW  = $clog2(DEPTH);

    localparam logic [BW-1:0] HALF_LOAD = BW'(DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LOAD = BW'(DIV - 1);
    localparam logic [BW-1:0] CNT_ZERO  = {BW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic          rx_meta_r;
    logic          rx_sync_r;
    state_t        state_r;
    logic [BW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    rd_data_r;
    logic          rd_valid_r;
    logic          frame_err_r;
    logic          overrun_r;

    logic          baud_tick_s;
    logic          push_req_s;
    logic          frame_bad_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_s;
    logic          drop_s;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [7:0]    head_nxt_s;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Stop-bit outcome is decoded combinationally so the FIFO write lands in the sample cycle.
    always_comb begin
        baud_tick_s = (baud_cnt_r == CNT_ZERO);
        push_req_s  = 1'b0;
        frame_bad_s = 1'b0;
        if ((state_r == ST_STOP) && baud_tick_s) begin
            push_req_s  = rx_sync_r;
            frame_bad_s = ~rx_sync_r;
        end else begin
            push_req_s  = 1'b0;
            frame_bad_s = 1'b0;
        end
    end

    // Receive FSM: half-bit delay to centre on the start bit, then one sample per bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_r    <= ST_START;
                        baud_cnt_r <= HALF_LOAD;
                    end else begin
                        baud_cnt_r <= CNT_ZERO;
                    end
                end
                ST_START: begin
                    if (baud_tick_s) begin
                        if (!rx_sync_r) begin
                            state_r    <= ST_DATA;
                            baud_cnt_r <= FULL_LOAD;
                            bit_idx_r  <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_tick_s) begin
                        shift_r    <= {rx_sync_r, shift_r[7:1]};
                        baud_cnt_r <= FULL_LOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_tick_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // FIFO control; a push into a full FIFO is accepted only when the head is popped that cycle.
    always_comb begin
        pop_s        = rd_en && (count_r != CNT_EMPTY);
        full_s       = (count_r == CNT_FULL);
        wr_s         = push_req_s && (!full_s || pop_s);
        drop_s       = push_req_s && full_s && !pop_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // The incoming byte becomes the head when it lands on the next read pointer.
        if (wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and registered show-ahead outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= CNT_EMPTY;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rd_data_r  <= head_nxt_s;
            rd_valid_r <= (count_nxt_s != CNT_EMPTY);
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (err_clr) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= frame_err_r | frame_bad_s;
            overrun_r   <= overrun_r | drop_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign count     = count_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule
